sbus_to_sram_like_wbuf: RTL and testbench

//   Bridge from the CPU-side sbus slave port to a single sram_like master port, with a posted-write buffer.

---
 rtl/sbus_to_sram_like_wbuf_if.sv | 22 ++
 rtl/sbus_to_sram_like_wbuf.sv | 188 ++++++++++++++++++
 tb/tb_sbus_to_sram_like_wbuf.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbus_to_sram_like_wbuf_if.sv
// CPU-side sbus bundle: the core drives the request fields and samples data_r/stall.
interface sbus_if #(
  parameter int ADDR_W = 32
);
  logic              en;
  logic              we;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_w;
  logic [31:0]       data_r;
  logic              stall;

  modport master (
    output en, we, size, addr, data_w,
    input  data_r, stall
  );

  modport slave (
    input  en, we, size, addr, data_w,
    output data_r, stall
  );
endinterface

// File: rtl/sbus_to_sram_like_wbuf.sv
// sbus slave to sram_like master bridge with a posted-write FIFO; writes drain in
// program order ahead of any read, and only one sram_like transaction is outstanding.
module sbus_to_sram_like_wbuf #(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  sbus_if.slave                       sbus,
  output logic                        sram_like_req,
  output logic                        sram_like_wr,
  output logic [1:0]                  sram_like_size,
  output logic [ADDR_W-1:0]           sram_like_addr,
  output logic [31:0]                 sram_like_wdata,
  input  logic [31:0]                 sram_like_rdata,
  input  logic                        sram_like_addr_ok,
  input  logic                        sram_like_data_ok,
  output logic                        wbuf_empty,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);
  localparam int IDX_W = $clog2(WBUF_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_ADDR = 3'd1,
    W_DATA = 3'd2,
    R_ADDR = 3'd3,
    R_DATA = 3'd4
  } state_t;

  state_t            state_r;
  state_t            next_state_s;
  logic [1:0]        fifo_size_r [WBUF_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_r [WBUF_DEPTH];
  logic [31:0]       fifo_data_r [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic [1:0]        rd_size_r;
  logic [31:0]       data_r_r;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              rd_start_s;
  logic              rd_done_s;

  function automatic logic [31:0] align_wdata(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  function automatic logic [31:0] align_rdata(input logic [31:0] d, input logic [1:0] off);
    return d >> {off, 3'b000};
  endfunction

  assign wr_idx_s   = wr_ptr_r[IDX_W-1:0];
  assign rd_idx_s   = rd_ptr_r[IDX_W-1:0];
  assign full_s     = (wr_ptr_r[IDX_W] != rd_ptr_r[IDX_W]) && (wr_idx_s == rd_idx_s);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign push_s     = sbus.en && sbus.we && !full_s;
  assign wbuf_count = wr_ptr_r - rd_ptr_r;
  assign wbuf_empty = empty_s && (state_r != W_ADDR) && (state_r != W_DATA);

  // CPU response: write stall is the registered full flag, reads release on their data_ok.
  always_comb begin
    sbus.stall  = 1'b0;
    sbus.data_r = data_r_r;
    if (rd_done_s) begin
      sbus.data_r = align_rdata(sram_like_rdata, rd_addr_r[1:0]);
    end else begin
      sbus.data_r = data_r_r;
    end
    if (!sbus.en) begin
      sbus.stall = 1'b0;
    end else if (sbus.we) begin
      sbus.stall = full_s;
    end else begin
      sbus.stall = !rd_done_s;
    end
  end

  // Port FSM next state and sram_like request decode.
  always_comb begin
    next_state_s    = state_r;
    sram_like_req   = 1'b0;
    sram_like_wr    = 1'b0;
    sram_like_size  = 2'd0;
    sram_like_addr  = {ADDR_W{1'b0}};
    sram_like_wdata = 32'h0000_0000;
    pop_s           = 1'b0;
    rd_start_s      = 1'b0;
    rd_done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        // A write pushed this cycle counts as buffered so its request rises next cycle.
        if (!empty_s || push_s) begin
          next_state_s = W_ADDR;
        end else if (sbus.en && !sbus.we) begin
          next_state_s = R_ADDR;
          rd_start_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      W_ADDR: begin
        sram_like_req   = 1'b1;
        sram_like_wr    = 1'b1;
        sram_like_size  = fifo_size_r[rd_idx_s];
        sram_like_addr  = fifo_addr_r[rd_idx_s];
        sram_like_wdata = fifo_data_r[rd_idx_s];
        if (sram_like_addr_ok) begin
          next_state_s = W_DATA;
        end else begin
          next_state_s = W_ADDR;
        end
      end
      W_DATA: begin
        if (sram_like_data_ok) begin
          pop_s        = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = W_DATA;
        end
      end
      R_ADDR: begin
        sram_like_req  = 1'b1;
        sram_like_size = rd_size_r;
        sram_like_addr = rd_addr_r;
        if (sram_like_addr_ok) begin
          next_state_s = R_DATA;
        end else begin
          next_state_s = R_ADDR;
        end
      end
      R_DATA: begin
        if (sram_like_data_ok) begin
          rd_done_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = R_DATA;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, FIFO pointers, latched read context and held read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      rd_addr_r <= {ADDR_W{1'b0}};
      rd_size_r <= 2'd0;
      data_r_r  <= 32'h0000_0000;
    end else begin
      state_r <= next_state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (rd_start_s) begin
        rd_addr_r <= sbus.addr;
        rd_size_r <= sbus.size;
      end
      if (rd_done_s) begin
        data_r_r <= align_rdata(sram_like_rdata, rd_addr_r[1:0]);
      end
    end
  end

  // Write-buffer storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_size_r[wr_idx_s] <= sbus.size;
      fifo_addr_r[wr_idx_s] <= sbus.addr;
      fifo_data_r[wr_idx_s] <= align_wdata(sbus.data_w, sbus.addr[1:0]);
    end
  end
endmodule

// File: tb/tb_sbus_to_sram_like_wbuf.sv
// Randomised bench for the posted-write bridge, checked against a queue-based transaction model.
module tb_sbus_to_sram_like_wbuf;
  localparam int DEPTH = 4;
  localparam int AW    = 32;

  typedef struct packed {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  gap;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sram_like_req;
  logic        sram_like_wr;
  logic [1:0]  sram_like_size;
  logic [31:0] sram_like_addr;
  logic [31:0] sram_like_wdata;
  logic [31:0] sram_like_rdata;
  logic        sram_like_addr_ok;
  logic        sram_like_data_ok;
  logic        wbuf_empty;
  logic [2:0]  wbuf_count;

  sbus_if #(.ADDR_W(AW)) sb ();

  sbus_to_sram_like_wbuf #(.WBUF_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .sbus              (sb),
    .sram_like_req     (sram_like_req),
    .sram_like_wr      (sram_like_wr),
    .sram_like_size    (sram_like_size),
    .sram_like_addr    (sram_like_addr),
    .sram_like_wdata   (sram_like_wdata),
    .sram_like_rdata   (sram_like_rdata),
    .sram_like_addr_ok (sram_like_addr_ok),
    .sram_like_data_ok (sram_like_data_ok),
    .wbuf_empty        (wbuf_empty),
    .wbuf_count        (wbuf_count)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  op_t         ops[$];
  op_t         cur = '0;
  int          pend = 0;
  bit          cpu_busy = 1'b0;
  bit          cpu_acc = 1'b0;
  int          gap_cnt = 0;
  bit          sl_busy = 1'b0;
  bit          sl_is_rd = 1'b0;
  int          sl_delay = 0;
  int          aok_pct = 100;
  int          fix_delay = -1;
  bit          force_rdata = 1'b0;
  bit          expect_req = 1'b0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  int          max_cnt = 0;
  int          stall_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_mul(input logic [1:0] off);
    logic [63:0] m;
    m = 64'd1;
    for (int i = 0; i < int'(off); i++) m = m * 64'd256;
    return m;
  endfunction

  function automatic logic [31:0] lane_w(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] p;
    p = {32'd0, d} * lane_mul(off);
    return p[31:0];
  endfunction

  function automatic logic [31:0] lane_r(input logic [31:0] d, input logic [1:0] off);
    logic [63:0] p;
    p = {32'd0, d} / lane_mul(off);
    return p[31:0];
  endfunction

  function automatic op_t mk(input bit we, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] data, input int gap);
    op_t o;
    o.we = we; o.size = size; o.addr = addr; o.data = data; o.gap = 4'(gap);
    return o;
  endfunction

  // Called away from the clock edge: compare DUT against the model, then advance the model.
  task automatic observe();
    bit  rd_done;
    wr_t w;
    rd_done = sl_busy && sl_is_rd && sram_like_data_ok;
    check_eq("wbuf_count", 32'(wbuf_count), 32'(pend));
    check_eq("wbuf_empty", 32'(wbuf_empty), 32'(pend == 0));
    if (expect_req) check_eq("req_latency", 32'(sram_like_req), 32'd1);
    else if (!sl_busy && pend == 0 && !(sb.en && !sb.we))
      check_eq("req_idle", 32'(sram_like_req), 32'd0);
    if (sb.en && sb.we) check_eq("wr_stall", 32'(sb.stall), 32'(pend >= DEPTH));
    if (sb.en && !sb.we) check_eq("rd_stall", 32'(sb.stall), 32'(!rd_done));
    if (sb.en && sb.stall) stall_cycles++;
    if (rd_done) last_rd = lane_r(sram_like_rdata, sb.addr[1:0]);
    check_eq("data_r", sb.data_r, last_rd);
    if (sram_like_req && sram_like_addr_ok) begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_eq("hs_is_write", 32'(sram_like_wr), 32'd1);
        check_eq("hs_waddr", sram_like_addr, w.addr);
        check_eq("hs_wsize", 32'(sram_like_size), 32'(w.size));
        check_eq("hs_wdata", sram_like_wdata, w.data);
        last_wdata = sram_like_wdata;
      end else begin
        check_eq("hs_rd_pending", 32'(sb.en && !sb.we), 32'd1);
        check_eq("hs_is_read", 32'(sram_like_wr), 32'd0);
        check_eq("hs_raddr", sram_like_addr, sb.addr);
        check_eq("hs_rsize", 32'(sram_like_size), 32'(sb.size));
        check_eq("hs_rwdata", sram_like_wdata, 32'h0);
      end
    end
    expect_req = 1'b0;
    if (sb.en && sb.we && !sb.stall) begin
      if (pend == 0 && !sl_busy) expect_req = 1'b1;
      w.size = sb.size; w.addr = sb.addr; w.data = lane_w(sb.data_w, sb.addr[1:0]);
      exp_q.push_back(w);
      pend++;
    end
    if (sb.en && !sb.stall) cpu_acc = 1'b1;
    if (sl_busy && sram_like_data_ok) begin
      if (!sl_is_rd) pend--;
      sl_busy = 1'b0;
    end
    if (sram_like_req && sram_like_addr_ok) begin
      sl_busy  = 1'b1;
      sl_is_rd = !sram_like_wr;
      sl_delay = (fix_delay >= 0) ? fix_delay : int'($urandom_range(3));
    end
    if (pend > max_cnt) max_cnt = pend;
  endtask

  task automatic drive();
    if (cpu_acc) begin cpu_busy = 1'b0; cpu_acc = 1'b0; end
    if (!cpu_busy) begin
      if (gap_cnt > 0) gap_cnt--;
      else if (ops.size() > 0) begin cur = ops.pop_front(); cpu_busy = 1'b1; gap_cnt = int'(cur.gap); end
    end
    sb.en = cpu_busy; sb.we = cur.we; sb.size = cur.size; sb.addr = cur.addr; sb.data_w = cur.data;
    if (sl_busy) begin
      sram_like_addr_ok = 1'b0;
      sram_like_data_ok = (sl_delay == 0);
      if (sl_delay > 0) sl_delay--;
    end else begin
      sram_like_addr_ok = (int'($urandom_range(99)) < aok_pct);
      sram_like_data_ok = 1'b0;
    end
    sram_like_rdata = force_rdata ? 32'h1234_5678 : $urandom();
  endtask

  task automatic run(input int budget, input bit until_idle);
    int n;
    n = 0;
    while (n < budget && !(until_idle && ops.size() == 0 && !cpu_busy && pend == 0 && !sl_busy && gap_cnt == 0)) begin
      @(negedge clk); observe();
      @(posedge clk); #1; drive();
      n++;
    end
    if (until_idle) check_eq("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1; sb.en = 1'b0; sram_like_addr_ok = 1'b0; sram_like_data_ok = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); ops.delete();
    pend = 0; cpu_busy = 1'b0; cpu_acc = 1'b0; gap_cnt = 0;
    sl_busy = 1'b0; last_rd = 32'h0; expect_req = 1'b0;
  endtask

  initial begin
    sb.en = 1'b0; sb.we = 1'b0; sb.size = 2'd0; sb.addr = 32'h0; sb.data_w = 32'h0;
    sram_like_addr_ok = 1'b0; sram_like_data_ok = 1'b0; sram_like_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(sram_like_req), 32'd0);
    check_eq("rst_count", 32'(wbuf_count), 32'd0);
    check_eq("rst_empty", 32'(wbuf_empty), 32'd1);
    check_eq("rst_data_r", sb.data_r, 32'h0);
    sb.en = 1'b1; sb.we = 1'b1; #1;
    check_eq("rst_wr_stall", 32'(sb.stall), 32'd0);
    sb.we = 1'b0; #1;
    check_eq("rst_rd_stall", 32'(sb.stall), 32'd1);
    sb.en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: single word write, addr_ok immediate, data_ok two cycles after it
    aok_pct = 100; fix_delay = 1;
    ops.push_back(mk(1'b1, 2'd2, 32'h8000_0010, 32'h1122_3344, 0));
    run(100, 1'b1);

    // T2: five back-to-back writes against a blocked port
    aok_pct = 0; fix_delay = -1; max_cnt = 0; stall_cycles = 0;
    for (int i = 0; i < 5; i++) ops.push_back(mk(1'b1, 2'd2, 32'h0000_1000 + 32'(4 * i), $urandom(), 0));
    run(12, 1'b0);
    check_eq("t2_peak_count", 32'(max_cnt), 32'd4);
    check_eq("t2_fifth_stalled", 32'(stall_cycles > 0), 32'd1);
    aok_pct = 100;
    run(300, 1'b1);

    // T3: two writes then a read; ordering checked at each handshake
    ops.push_back(mk(1'b1, 2'd2, 32'h0000_00A0, 32'hAAAA_0001, 0));
    ops.push_back(mk(1'b1, 2'd2, 32'h0000_00B0, 32'hBBBB_0002, 0));
    ops.push_back(mk(1'b0, 2'd2, 32'h0000_00C0, 32'h0, 0));
    run(300, 1'b1);

    // T4: sub-word lane placement on write and read
    force_rdata = 1'b1;
    ops.push_back(mk(1'b1, 2'd0, 32'h1000_0003, 32'h0000_00AB, 0));
    ops.push_back(mk(1'b0, 2'd1, 32'h2000_0002, 32'h0, 0));
    run(300, 1'b1);
    check_eq("t4_wdata", last_wdata, 32'hAB00_0000);
    check_eq("t4_data_r", last_rd, 32'h0000_1234);
    force_rdata = 1'b0;

    // T5: reset while a write sits in W_DATA with three entries buffered
    aok_pct = 0;
    for (int i = 0; i < 3; i++) ops.push_back(mk(1'b1, 2'd2, 32'h0000_2000 + 32'(4 * i), $urandom(), 0));
    run(4, 1'b0);
    aok_pct = 100; fix_delay = 6;
    run(3, 1'b0);
    check_eq("t5_pre_count", 32'(wbuf_count), 32'd3);
    apply_reset();
    @(negedge clk);
    check_eq("t5_req", 32'(sram_like_req), 32'd0);
    check_eq("t5_count", 32'(wbuf_count), 32'd0);
    check_eq("t5_empty", 32'(wbuf_empty), 32'd1);
    check_eq("t5_data_r", sb.data_r, 32'h0);
    fix_delay = -1;
    ops.push_back(mk(1'b1, 2'd2, 32'h0000_3000, 32'hCAFE_F00D, 0));
    run(100, 1'b1);

    // T6: ten writes then a random mix, random handshake delays
    aok_pct = 50;
    for (int i = 0; i < 10; i++) ops.push_back(mk(1'b1, 2'($urandom_range(2)), $urandom(), $urandom(), 0));
    for (int i = 0; i < 60; i++)
      ops.push_back(mk(($urandom_range(99) < 70), 2'($urandom_range(2)), $urandom(), $urandom(),
                       int'($urandom_range(2))));
    run(5000, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
